immediate_generator: RTL and testbench

Registered RV32I immediate generator for the core's decode stage. It takes the 32-bit instruction word and a 3-bit immediate-format select from the control unit. It extracts and reassembles the immediate bit fields for that format and sign- or zero-extends the result to 32 bits. It presents the value on a registered output one clock later, for the ALU operand mux, branch/jump target adder and LUI/AUIPC path.

---
 rtl/immediate_generator_if.sv | 10 +
 rtl/immediate_generator.sv | 46 ++++
 tb/tb_immediate_generator.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/immediate_generator_if.sv
// Decode-stage immediate bus: the instruction word and format select go in,
// and the extended immediate comes back one cycle later.
interface immediate_generator_if;
  logic [31:0] Instr;
  logic [2:0]  ImmSel;
  logic [31:0] Imm;

  modport master (output Instr, output ImmSel, input Imm);
  modport slave  (input Instr, input ImmSel, output Imm);
endinterface

// File: rtl/immediate_generator.sv
// Registered RV32I immediate generator: reassembles the immediate fields for
// the selected format, extends them to 32 bits and registers the result.
module immediate_generator (
  input  logic                  clk,
  input  logic                  rst_n,
  immediate_generator_if.slave  bus
);

  logic [31:0] next_imm_s;
  logic [31:0] imm_r;
  logic        sign_s;
  logic        unused_opcode_s;

  assign sign_s          = bus.Instr[31];
  assign unused_opcode_s = ^bus.Instr[6:0];

  // Field extraction and extension per format; unknown selects fall to zero.
  always_comb begin
    next_imm_s = 32'h0000_0000;
    case (bus.ImmSel)
      3'b000: next_imm_s = {{20{sign_s}}, bus.Instr[31:20]};
      3'b001: next_imm_s = {{20{sign_s}}, bus.Instr[31:25], bus.Instr[11:7]};
      3'b010: next_imm_s = {{19{sign_s}}, bus.Instr[31], bus.Instr[7],
                            bus.Instr[30:25], bus.Instr[11:8], 1'b0};
      3'b011: next_imm_s = {{11{sign_s}}, bus.Instr[31], bus.Instr[19:12],
                            bus.Instr[20], bus.Instr[30:21], 1'b0};
      3'b100: next_imm_s = {bus.Instr[31:12], 12'h000};
      3'b101: next_imm_s = {27'b0, bus.Instr[24:20]};
      3'b110: next_imm_s = {27'b0, bus.Instr[19:15]};
      3'b111: next_imm_s = 32'h0000_0000;
      default: next_imm_s = 32'h0000_0000;
    endcase
  end

  // Output register loads every cycle; reset clears it without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_r <= 32'h0000_0000;
    end else begin
      imm_r <= next_imm_s;
    end
  end

  assign bus.Imm = imm_r;

endmodule

// File: tb/tb_immediate_generator.sv
// Self-checking bench for immediate_generator: directed vector table, timing
// sequences and randomized stimulus against an arithmetic reference model.
module tb_immediate_generator;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  immediate_generator_if bus ();

  immediate_generator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [21];

  // Reference: immediates computed as signed integer offsets from their fields.
  function automatic logic [31:0] ref_imm(input logic [31:0] w, input logic [2:0] sel);
    longint v;
    longint u;
    u = longint'(w);
    v = 0;
    case (sel)
      3'd0: begin
        v = u / 1048576;
        if (w[31]) v = v - 4096;
      end
      3'd1: begin
        v = (u / 33554432) * 32 + (u / 128) % 32;
        if (w[31]) v = v - 4096;
      end
      3'd2: begin
        v = ((u / 256) % 16) * 2 + ((u / 33554432) % 64) * 32 + ((u / 128) % 2) * 2048;
        if (w[31]) v = v - 4096;
      end
      3'd3: begin
        v = ((u / 2097152) % 1024) * 2 + ((u / 1048576) % 2) * 2048 + ((u / 4096) % 256) * 4096;
        if (w[31]) v = v - 1048576;
      end
      3'd4: v = (u / 4096) * 4096;
      3'd5: v = (u / 1048576) % 32;
      3'd6: v = (u / 32768) % 32;
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: Imm=%h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [31:0] instr, input logic [2:0] sel);
    bus.Instr  = instr;
    bus.ImmSel = sel;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ri;
    logic [2:0]  rs;
    tests_run    = 0;
    tests_failed = 0;

    vecs[0]  = '{32'h00A1_0093, 3'b000, 32'h0000_000A};
    vecs[1]  = '{32'h0051_A623, 3'b001, 32'h0000_000C};
    vecs[2]  = '{32'h0020_8A63, 3'b010, 32'h0000_0014};
    vecs[3]  = '{32'h0200_00EF, 3'b011, 32'h0000_0020};
    vecs[4]  = '{32'h1234_52B7, 3'b100, 32'h1234_5000};
    vecs[5]  = '{32'hFFF0_0093, 3'b000, 32'hFFFF_FFFF};
    vecs[6]  = '{32'hFE00_0FA3, 3'b001, 32'hFFFF_FFFF};
    vecs[7]  = '{32'h8000_0063, 3'b010, 32'hFFFF_F000};
    vecs[8]  = '{32'h8000_006F, 3'b011, 32'hFFF0_0000};
    vecs[9]  = '{32'hFFFF_F037, 3'b100, 32'hFFFF_F000};
    vecs[10] = '{32'h41F0_5013, 3'b101, 32'h0000_001F};
    vecs[11] = '{32'hFFFF_FFFF, 3'b110, 32'h0000_001F};
    vecs[12] = '{32'hDEAD_BEEF, 3'b111, 32'h0000_0000};
    vecs[13] = '{32'hFFFF_FFFF, 3'b000, 32'hFFFF_FFFF};
    vecs[14] = '{32'hFFFF_FFFF, 3'b001, 32'hFFFF_FFFF};
    vecs[15] = '{32'hFFFF_FFFF, 3'b010, 32'hFFFF_FFFE};
    vecs[16] = '{32'hFFFF_FFFF, 3'b011, 32'hFFFF_FFFE};
    vecs[17] = '{32'hFFFF_FFFF, 3'b100, 32'hFFFF_F000};
    vecs[18] = '{32'hFFFF_FFFF, 3'b101, 32'h0000_001F};
    vecs[19] = '{32'hFFFF_FFFF, 3'b110, 32'h0000_001F};
    vecs[20] = '{32'hFFFF_FFFF, 3'b111, 32'h0000_0000};

    // Reset held across edges with all-ones input.
    rst_n      = 1'b0;
    bus.Instr  = 32'hFFFF_FFFF;
    bus.ImmSel = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", bus.Imm, 32'h0000_0000);
    rst_n = 1'b1;

    // Directed vectors, back-to-back, one result per cycle.
    for (int i = 0; i < 21; i++) begin
      step(vecs[i].instr, vecs[i].sel);
      check($sformatf("vec%0d", i), bus.Imm, vecs[i].exp);
    end

    // Inputs changing between edges must not reach Imm early.
    step(32'h00A1_0093, 3'b000);
    check("hold_pre", bus.Imm, 32'h0000_000A);
    #2;
    bus.Instr  = 32'h1234_52B7;
    bus.ImmSel = 3'b100;
    #1;
    check("hold_mid", bus.Imm, 32'h0000_000A);
    @(posedge clk);
    #1;
    check("hold_next", bus.Imm, 32'h1234_5000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("stable%0d", i), bus.Imm, 32'h1234_5000);
    end

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 300; i++) begin
      ri = $urandom;
      rs = 3'($urandom_range(7, 0));
      step(ri, rs);
      check($sformatf("rand%0d_sel%0d_%h", i, rs, ri), bus.Imm, ref_imm(ri, rs));
    end

    // Asynchronous reset mid-cycle clears a nonzero value before the next edge.
    step(32'hFFF0_0093, 3'b000);
    check("pre_areset", bus.Imm, 32'hFFFF_FFFF);
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_now", bus.Imm, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("areset_edge", bus.Imm, 32'h0000_0000);
    rst_n = 1'b1;
    step(32'h1234_52B7, 3'b100);
    check("post_release", bus.Imm, 32'h1234_5000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
